alu_issue_unit: RTL and testbench

- Drives the RV32I ALU (ports A, B, FUNC, sub_sra in; S, EQ, LU, LS out) from the decode stage.
- Accepts one instruction and its operand values per valid/ready handshake, then decodes FUNC, sub_sra and operand selection.
- Drives the ALU from registered operands, then captures S and the flags.
- Presents a writeback/branch result on a second valid/ready handshake.
- Sits between decode and writeback. The ALU is instantiated outside this block.

---
 rtl/alu_issue_unit.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_unit
//  Description : Issue stage for an external RV32I ALU. Accepts one decoded
//                instruction per valid/ready handshake, drives the ALU from
//                registered operands, captures the sum and compare flags,
//                and presents a writeback/branch result on a second
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    // Decode-side handshake
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] pc,

    // External ALU
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_func,
    output logic            alu_sub_sra,
    input  logic [XLEN-1:0] alu_s,
    input  logic            alu_eq,
    input  logic            alu_lu,
    input  logic            alu_ls,

    // Writeback / branch handshake
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_we,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            illegal
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] c_F7_BASE    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    localparam logic [2:0] c_F3_ADD     = 3'b000;
    localparam logic [2:0] c_F3_SLL     = 3'b001;
    localparam logic [2:0] c_F3_SR      = 3'b101;

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_accept;
    logic w_capture;
    logic w_release;

    // ------------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_shamt;
    logic [2:0]      w_func_map;
    logic [XLEN-1:0] w_br_target;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rd     = instr[11:7];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_u  = {instr[31:12], 12'd0};
    assign w_imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_shamt  = {27'd0, instr[24:20]};

    // The ALU places unsigned compare at 010 and signed compare at 011,
    // the reverse of funct3, so only those two codes are exchanged.
    assign w_func_map = (w_funct3[2:1] == 2'b01) ? {2'b01, ~w_funct3[0]} : w_funct3;

    // Branch target is computed at accept time while pc is still valid.
    assign w_br_target = pc + w_imm_b;

    // ------------------------------------------------------------------------
    // Decoded values for the incoming instruction
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_dec_a;
    logic [XLEN-1:0] w_dec_b;
    logic [2:0]      w_dec_func;
    logic            w_dec_sub;
    logic            w_dec_illegal;
    logic            w_dec_branch;
    logic            w_dec_write;

    // Decode opcode/funct fields into ALU controls and legality.
    always_comb begin
        w_dec_a       = '0;
        w_dec_b       = '0;
        w_dec_func    = c_F3_ADD;
        w_dec_sub     = 1'b0;
        w_dec_illegal = 1'b0;
        w_dec_branch  = 1'b0;
        w_dec_write   = 1'b0;

        case (w_opcode)
            c_OPC_OP: begin
                w_dec_a     = rs1_val;
                w_dec_b     = rs2_val;
                w_dec_func  = w_func_map;
                w_dec_write = 1'b1;
                w_dec_sub   = instr[30] && ((w_funct3 == c_F3_ADD) || (w_funct3 == c_F3_SR));
                if (w_funct7 == c_F7_BASE) begin
                    w_dec_illegal = 1'b0;
                end else if ((w_funct7 == c_F7_ALT) &&
                             ((w_funct3 == c_F3_ADD) || (w_funct3 == c_F3_SR))) begin
                    w_dec_illegal = 1'b0;
                end else begin
                    w_dec_illegal = 1'b1;
                end
            end

            c_OPC_OP_IMM: begin
                w_dec_a     = rs1_val;
                w_dec_b     = w_imm_i;
                w_dec_func  = w_func_map;
                w_dec_write = 1'b1;
                if (w_funct3 == c_F3_SLL) begin
                    w_dec_b       = w_shamt;
                    w_dec_illegal = (w_funct7 != c_F7_BASE);
                end else if (w_funct3 == c_F3_SR) begin
                    // Only the shift-right pair uses instr[30]; ADDI must not.
                    w_dec_b       = w_shamt;
                    w_dec_sub     = instr[30];
                    w_dec_illegal = (w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT);
                end
            end

            c_OPC_LUI: begin
                w_dec_a     = '0;
                w_dec_b     = w_imm_u;
                w_dec_write = 1'b1;
            end

            c_OPC_AUIPC: begin
                w_dec_a     = pc;
                w_dec_b     = w_imm_u;
                w_dec_write = 1'b1;
            end

            c_OPC_BRANCH: begin
                // Subtract so the ALU produces the EQ/LU/LS flags for rs1 vs rs2.
                w_dec_a       = rs1_val;
                w_dec_b       = rs2_val;
                w_dec_sub     = 1'b1;
                w_dec_branch  = 1'b1;
                w_dec_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end

            default: begin
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction context held from accept until capture
    // ------------------------------------------------------------------------
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic            r_is_branch;
    logic            r_illegal;
    logic            r_we;
    logic [XLEN-1:0] r_br_target;

    logic            w_br_cond;

    // Select the branch condition from the captured ALU flags.
    always_comb begin
        w_br_cond = 1'b0;
        case (r_funct3)
            3'b000:  w_br_cond = alu_eq;
            3'b001:  w_br_cond = ~alu_eq;
            3'b100:  w_br_cond = alu_ls;
            3'b101:  w_br_cond = ~alu_ls;
            3'b110:  w_br_cond = alu_lu;
            3'b111:  w_br_cond = ~alu_lu;
            default: w_br_cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, handshake strobes and in_ready.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        in_ready     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_capture    = 1'b1;
                w_state_next = ST_RESP;
            end

            ST_RESP: begin
                if (out_valid && out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------

    // Latch ALU operands and transaction context on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_func    <= 3'b000;
            alu_sub_sra <= 1'b0;
            r_rd        <= 5'd0;
            r_funct3    <= 3'b000;
            r_is_branch <= 1'b0;
            r_illegal   <= 1'b0;
            r_we        <= 1'b0;
            r_br_target <= '0;
        end else if (w_accept) begin
            alu_a       <= w_dec_a;
            alu_b       <= w_dec_b;
            alu_func    <= w_dec_func;
            alu_sub_sra <= w_dec_sub;
            r_rd        <= w_rd;
            r_funct3    <= w_funct3;
            r_is_branch <= w_dec_branch;
            r_illegal   <= w_dec_illegal;
            r_we        <= w_dec_write && !w_dec_illegal && (w_rd != 5'd0);
            r_br_target <= w_br_target;
        end
    end

    // Capture ALU result into the response registers; clear valid on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rd    <= 5'd0;
            out_data  <= '0;
            out_we    <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= '0;
            illegal   <= 1'b0;
        end else if (w_capture) begin
            out_valid <= 1'b1;
            out_rd    <= r_rd;
            out_data  <= (r_is_branch || r_illegal) ? '0 : alu_s;
            out_we    <= r_we;
            br_taken  <= r_is_branch && !r_illegal && w_br_cond;
            br_target <= (r_is_branch && !r_illegal) ? r_br_target : '0;
            illegal   <= r_illegal;
        end else if (w_release) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_unit
//  Description : Self-checking bench for alu_issue_unit with a behavioural
//                ALU and an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_unit;

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SLL  = 3'd1;
    localparam logic [2:0] c_ALU_SLTU = 3'd2;
    localparam logic [2:0] c_ALU_SLT  = 3'd3;
    localparam logic [2:0] c_ALU_XOR  = 3'd4;
    localparam logic [2:0] c_ALU_SR   = 3'd5;
    localparam logic [2:0] c_ALU_OR   = 3'd6;
    localparam logic [2:0] c_ALU_AND  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] pc = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_func;
    logic        alu_sub_sra;
    logic [31:0] alu_s;
    logic        alu_eq;
    logic        alu_lu;
    logic        alu_ls;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_we;
    logic        br_taken;
    logic [31:0] br_target;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .pc          (pc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_func    (alu_func),
        .alu_sub_sra (alu_sub_sra),
        .alu_s       (alu_s),
        .alu_eq      (alu_eq),
        .alu_lu      (alu_lu),
        .alu_ls      (alu_ls),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_data    (out_data),
        .out_we      (out_we),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU sitting outside the issue unit.
    always_comb begin
        alu_s = '0;
        case (alu_func)
            3'd0: alu_s = alu_sub_sra ? (alu_a - alu_b) : (alu_a + alu_b);
            3'd1: alu_s = alu_a << alu_b[4:0];
            3'd2: alu_s = {31'd0, (alu_a < alu_b)};
            3'd3: alu_s = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            3'd4: alu_s = alu_a ^ alu_b;
            3'd5: begin
                if (alu_sub_sra) alu_s = $signed(alu_a) >>> alu_b[4:0];
                else             alu_s = alu_a >> alu_b[4:0];
            end
            3'd6: alu_s = alu_a | alu_b;
            3'd7: alu_s = alu_a & alu_b;
            default: alu_s = '0;
        endcase
    end
    assign alu_eq = (alu_a == alu_b);
    assign alu_lu = (alu_a < alu_b);
    assign alu_ls = ($signed(alu_a) < $signed(alu_b));

    typedef struct packed {
        logic        ill;
        logic        we;
        logic        bt;
        logic        is_br;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] tgt;
        logic        chk_alu;
        logic        shift;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  func;
        logic        sub;
    } exp_t;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sra32(input logic [31:0] x, input logic [4:0] n);
        logic signed [31:0] s;
        s = x;
        return s >>> n;
    endfunction

    function automatic logic [31:0] lt_s(input logic [31:0] x, input logic [31:0] y);
        return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] lt_u(input logic [31:0] x, input logic [31:0] y);
        return (x < y) ? 32'd1 : 32'd0;
    endfunction

    // Instruction-level reference: what RV32I says the result should be.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] pcv);
        exp_t e;
        logic [31:0] imm_i, imm_u, imm_b;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  sh;
        e     = '0;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        sh    = ins[24:20];
        e.rd  = ins[11:7];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_u = {ins[31:12], 12'd0};
        imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        e.chk_alu = 1'b1;
        case (op)
            7'b0110011: begin
                e.a = r1; e.b = r2; e.we = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: begin e.data = r1 + r2;          e.func = c_ALU_ADD;  end
                        3'd1: begin e.data = r1 << r2[4:0];    e.func = c_ALU_SLL;  end
                        3'd2: begin e.data = lt_s(r1, r2);     e.func = c_ALU_SLT;  end
                        3'd3: begin e.data = lt_u(r1, r2);     e.func = c_ALU_SLTU; end
                        3'd4: begin e.data = r1 ^ r2;          e.func = c_ALU_XOR;  end
                        3'd5: begin e.data = r1 >> r2[4:0];    e.func = c_ALU_SR;   end
                        3'd6: begin e.data = r1 | r2;          e.func = c_ALU_OR;   end
                        default: begin e.data = r1 & r2;       e.func = c_ALU_AND;  end
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    e.data = r1 - r2; e.func = c_ALU_ADD; e.sub = 1'b1;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    e.data = sra32(r1, r2[4:0]); e.func = c_ALU_SR; e.sub = 1'b1;
                end else begin
                    e.ill = 1'b1;
                end
            end
            7'b0010011: begin
                e.a = r1; e.b = imm_i; e.we = 1'b1;
                case (f3)
                    3'd0: begin e.data = r1 + imm_i;        e.func = c_ALU_ADD;  end
                    3'd2: begin e.data = lt_s(r1, imm_i);   e.func = c_ALU_SLT;  end
                    3'd3: begin e.data = lt_u(r1, imm_i);   e.func = c_ALU_SLTU; end
                    3'd4: begin e.data = r1 ^ imm_i;        e.func = c_ALU_XOR;  end
                    3'd6: begin e.data = r1 | imm_i;        e.func = c_ALU_OR;   end
                    3'd7: begin e.data = r1 & imm_i;        e.func = c_ALU_AND;  end
                    3'd1: begin
                        e.shift = 1'b1; e.b = {27'd0, sh}; e.func = c_ALU_SLL;
                        if (f7 != 7'h00) e.ill = 1'b1;
                        else             e.data = r1 << sh;
                    end
                    default: begin
                        e.shift = 1'b1; e.b = {27'd0, sh}; e.func = c_ALU_SR;
                        if (f7 == 7'h00) e.data = r1 >> sh;
                        else if (f7 == 7'h20) begin e.data = sra32(r1, sh); e.sub = 1'b1; end
                        else e.ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                e.a = 32'd0; e.b = imm_u; e.data = imm_u; e.we = 1'b1; e.func = c_ALU_ADD;
            end
            7'b0010111: begin
                e.a = pcv; e.b = imm_u; e.data = pcv + imm_u; e.we = 1'b1; e.func = c_ALU_ADD;
            end
            7'b1100011: begin
                e.is_br = 1'b1; e.a = r1; e.b = r2; e.func = c_ALU_ADD; e.sub = 1'b1;
                e.tgt = pcv + imm_b; e.data = 32'd0;
                case (f3)
                    3'd0: e.bt = (r1 == r2);
                    3'd1: e.bt = (r1 != r2);
                    3'd4: e.bt = ($signed(r1) <  $signed(r2));
                    3'd5: e.bt = ($signed(r1) >= $signed(r2));
                    3'd6: e.bt = (r1 <  r2);
                    3'd7: e.bt = (r1 >= r2);
                    default: e.ill = 1'b1;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.we = 1'b0; e.bt = 1'b0; e.chk_alu = 1'b0;
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic check_outputs(input exp_t e);
        check_value("out_valid", out_valid, 1);
        check_value("in_ready_busy", in_ready, 0);
        check_value("out_we", out_we, e.we);
        check_value("illegal", illegal, e.ill);
        check_value("br_taken", br_taken, e.bt);
        if (!e.ill) begin
            check_value("out_data", out_data, e.data);
            check_value("br_target", br_target, e.tgt);
            if (!e.is_br) check_value("out_rd", out_rd, e.rd);
        end
    endtask

    // One full transaction: accept, EXEC, RESP with 'stall' cycles of backpressure.
    task automatic run_txn(input logic [31:0] ins, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] pcv, input int stall);
        exp_t e;
        e = model(ins, r1, r2, pcv);
        @(negedge clk);
        check_value("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; instr = ins; rs1_val = r1; rs2_val = r2; pc = pcv;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Producer keeps presenting something while busy; it must be ignored.
        instr = $urandom; rs1_val = $urandom; rs2_val = $urandom; pc = $urandom;
        @(negedge clk);
        check_value("exec_in_ready", in_ready, 0);
        check_value("exec_out_valid", out_valid, 0);
        if (e.chk_alu) begin
            check_value("alu_func", alu_func, e.func);
            check_value("alu_sub_sra", alu_sub_sra, e.sub);
            check_value("alu_a", alu_a, e.a);
            if (e.shift) check_value("alu_b_shamt", alu_b & 32'h1F, e.b);
            else         check_value("alu_b", alu_b, e.b);
        end
        @(negedge clk);
        check_outputs(e);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_outputs(e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_value("post_hs_out_valid", out_valid, 0);
        check_value("post_hs_in_ready", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    function automatic logic [6:0] pick_f7();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      return 7'h00;
        else if (r < 9) return 7'h20;
        else            return 7'($urandom);
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [4:0]  rd, s1, s2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int kind;
        w    = $urandom;
        rd   = 5'($urandom);
        s1   = 5'($urandom);
        s2   = 5'($urandom);
        f3   = 3'($urandom);
        imm  = 12'($urandom);
        kind = $urandom_range(0, 9);
        case (kind)
            0, 1, 2: return {pick_f7(), s2, s1, f3, rd, 7'b0110011};
            3, 4: begin
                if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = pick_f7();
                return {imm, s1, f3, rd, 7'b0010011};
            end
            5: return {w[31:12], rd, 7'b0110111};
            6: return {w[31:12], rd, 7'b0010111};
            7, 8: return {w[31:25], s2, s1, f3, w[11:7], 7'b1100011};
            default: return w;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r2, pv;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_out_data", out_data, 0);
        check_value("rst_alu_a", alu_a, 0);
        check_value("rst_alu_func", alu_func, 0);
        check_value("rst_illegal", illegal, 0);
        check_value("rst_br_target", br_target, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("in_ready_after_rst", in_ready, 1);

        // Directed cases
        run_txn(32'h002081B3, 32'd5, 32'd7, 32'h0, 0);                 // ADD
        run_txn(32'h402081B3, 32'd5, 32'd7, 32'h0, 1);                 // SUB
        run_txn(32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 32'h0, 0);          // SLT
        run_txn(32'h0020B1B3, 32'hFFFFFFFF, 32'd1, 32'h0, 0);          // SLTU
        run_txn(32'h4040D193, 32'h80000000, 32'd0, 32'h0, 0);          // SRAI
        run_txn(32'h40008193, 32'd10, 32'd0, 32'h0, 0);                // ADDI imm with bit30 set
        run_txn(32'h00208863, 32'd9, 32'd9, 32'h100, 0);               // BEQ taken
        run_txn(32'h00208863, 32'd9, 32'd8, 32'h100, 0);               // BEQ not taken
        run_txn(32'h002081B3, 32'h12345678, 32'h11111111, 32'h0, 3);   // backpressure
        run_txn(32'h202081B3, 32'd5, 32'd7, 32'h0, 0);                 // illegal funct7
        run_txn(32'h00208033, 32'd5, 32'd7, 32'h0, 0);                 // ADD to x0

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 32'($urandom);
            if ($urandom_range(0, 4) == 0) r1 = 32'h80000000;
            pv = $urandom & 32'hFFFFFFFC;
            run_txn(gen_instr(), r1, r2, pv, $urandom_range(0, 2));
        end

        // Reset asserted mid-RESP drops the transaction asynchronously
        @(negedge clk);
        in_valid = 1'b1; instr = 32'h402081B3; rs1_val = 32'd5; rs2_val = 32'd7; pc = 32'h40;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_value("pre_rst_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("arst_out_valid", out_valid, 0);
        check_value("arst_out_data", out_data, 0);
        check_value("arst_out_we", out_we, 0);
        check_value("arst_out_rd", out_rd, 0);
        check_value("arst_alu_a", alu_a, 0);
        check_value("arst_alu_b", alu_b, 0);
        check_value("arst_alu_sub", alu_sub_sra, 0);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rel_in_ready", in_ready, 1);
        check_value("rel_out_valid", out_valid, 0);
        @(negedge clk);
        check_value("rel_out_valid2", out_valid, 0);
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
